ser2par_deser: RTL and testbench
================================

Name: ser2par_deser

Overview:
- Downstream stage of the single-bit dff path.
- Consumes the registered serial bit stream (dff dout) with a qualifying valid.
- Detects a start bit, then assembles WIDTH-bit words LSB-first.
- Buffers completed words in a small FWFT FIFO with valid/ready output; a drv/mon pair reaches it through s2cif.

Parameters:
- WIDTH, 8: data bits per frame (1..32).
- DEPTH, 4: output FIFO entries; power of 2, >=2.
- START_VAL, 1: sin value that marks a start bit while IDLE.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset; asserted when 0, released synchronously to clk by the environment.
- sin  in  1  serial data bit (dff dout).
- sin_vld  in  1  sin is sampled only when 1.
- out_data  out  WIDTH  head-of-FIFO word.
- out_vld  out  1  FIFO non-empty.
- out_rdy  in  1  consumer accepts head when out_vld&&out_rdy.
- out_perr  out  1  parity error flag of the head word; 0 when the feature is compiled out.
- ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  clears ovf.
- busy  out  1  1 while the FSM is not IDLE.
- level  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset values (rst=0, asynchronous): FSM=IDLE, bit counter=0, shift register=0, FIFO empty, out_vld=0, out_data=0, out_perr=0, ovf=0, busy=0, level=0.
- FSM states: IDLE, DATA, PAR (PAR exists only with the macro). Transitions occur only on cycles with sin_vld=1.
- IDLE: sin==START_VAL -> DATA, counter=0. Any other value stays IDLE.
- DATA: sin is shifted in at bit[counter], LSB first, and counter increments.
  - On bit WIDTH-1: with the macro -> PAR; without it -> push the word and return to IDLE.
- PAR: sin is taken as the parity bit -> push {word, perr}, return to IDLE.
- Frames are back-to-back capable: a start bit is accepted the cycle after returning to IDLE.
- sin_vld=0: FSM, counter and shift register hold (stall). There is no timeout.
- Push latency: the word is written at the clk edge that samples its last bit. out_vld=1 and out_data are valid from that edge onward (1 cycle after the last bit is presented).
- FIFO is first-word-fall-through. A pop occurs when out_vld&&out_rdy; the next entry appears on the following cycle.
- Pop with FIFO empty: ignored.
- Push and pop in the same cycle: both occur and level is unchanged. This also applies when full, so the push is accepted.
- Push when full with no pop: the word is dropped, FIFO contents are unchanged, and ovf is set at that edge.
- ovf stays 1 until ovf_clr=1. If a set and ovf_clr occur in the same cycle, the set wins.
- Read/write pointers are log2(DEPTH) bits and wrap naturally; level is computed from a separate counter.
- Reset mid-frame discards the partial word and all FIFO contents.
- sin is sampled only on sin_vld; X on sin while sin_vld=0 has no effect.

Optional Feature:
- Macro: SER2PAR_PARITY_EN.
- Defined: each frame carries one extra even-parity bit after the WIDTH data bits. out_perr for the stored entry = (^word) ^ parity_bit. The FIFO entry width is WIDTH+1.
- Undefined: there is no PAR state, frames are start+WIDTH bits, out_perr is tied 0, and the FIFO entry width is WIDTH.

Test Plan:
- Reset then single frame: rst low for 25 ns, then with sin_vld=1 drive 1, then 1,0,1,0,0,1,0,1 -> out_data=8'hA5, out_vld=1 at the edge sampling the last bit, level=1, busy=0 afterwards.
- Stall: same 8'hA5 frame with sin_vld=0 inserted for 3 cycles after bit 3 -> out_data=8'hA5, and no push occurs during the stall.
- Back-to-back and FIFO fill: 5 frames 8'h01..8'h05 with out_rdy=0 -> level=4, ovf=1 after frame 5. Then out_rdy=1 -> pops 01,02,03,04 in order. ovf stays 1 until ovf_clr pulses.
- Full with simultaneous pop: FIFO full, out_rdy=1 on the cycle frame 8'h3C completes -> ovf remains 0, level stays 4, and 8'h3C is the last word popped.
- Reset mid-operation: rst=0 after 4 data bits and with level=2 -> out_vld=0 and level=0 immediately (asynchronously). A following frame 8'hFF is received correctly.
- With SER2PAR_PARITY_EN: frame 8'hA5 plus parity 0 -> out_perr=0; the same frame with parity 1 -> out_perr=1, out_data=8'hA5.

Source files
------------

// File: rtl/ser2par_deser_if.sv
// Serial-in / word-out bus for ser2par_deser.
// master: the driver/monitor side (drives sin, sin_vld, out_rdy).
// slave:  the deserializer side.
interface ser2par_deser_if #(
    parameter int WIDTH = 8
);
    logic             sin;
    logic             sin_vld;
    logic [WIDTH-1:0] out_data;
    logic             out_vld;
    logic             out_rdy;
    logic             out_perr;

    modport master (
        output sin, sin_vld, out_rdy,
        input  out_data, out_vld, out_perr
    );

    modport slave (
        input  sin, sin_vld, out_rdy,
        output out_data, out_vld, out_perr
    );
endinterface

// File: rtl/ser2par_deser.sv
// ser2par_deser: start-bit framed serial to parallel deserializer with an
// FWFT output FIFO.
// Optional macro SER2PAR_PARITY_EN: each frame carries a trailing even-parity
// bit, and the FIFO stores a parity-error flag alongside each word.
//
// state | meaning
// IDLE  | waiting for sin == START_VAL on a valid cycle
// DATA  | collecting WIDTH data bits, LSB first
// PAR   | collecting the parity bit (SER2PAR_PARITY_EN only)
module ser2par_deser #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter bit START_VAL = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    ser2par_deser_if.slave                 bus,
    output logic                           ovf,
    input  logic                           ovf_clr,
    output logic                           busy,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);
`ifdef SER2PAR_PARITY_EN
    localparam int ENT_W = WIDTH + 1;
`else
    localparam int ENT_W = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

`ifdef SER2PAR_PARITY_EN
    typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   sreg;
    logic [WIDTH-1:0]   word_cur;
    logic               cnt_clr;
    logic               shift_en;
    logic               push;
    logic [ENT_W-1:0]   push_ent;

    logic [ENT_W-1:0]   mem [DEPTH];
    logic [AW-1:0]      wptr, rptr;
    logic [LVL_W-1:0]   count;
    logic               full;
    logic               pop;
    logic               push_ok;

    // Current word with the incoming bit merged at the counter position.
    always_comb begin
        word_cur      = sreg;
        word_cur[cnt] = bus.sin;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and datapath controls; every transition needs sin_vld.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        push      = 1'b0;
`ifdef SER2PAR_PARITY_EN
        push_ent  = {(^sreg) ^ bus.sin, sreg};
`else
        push_ent  = word_cur;
`endif
        case (state)
            IDLE: begin
                if (bus.sin_vld && (bus.sin == START_VAL)) begin
                    state_nxt = DATA;
                    cnt_clr   = 1'b1;
                end
            end
            DATA: begin
                if (bus.sin_vld) begin
                    shift_en = 1'b1;
                    if (cnt == LAST_BIT) begin
`ifdef SER2PAR_PARITY_EN
                        state_nxt = PAR;
`else
                        state_nxt = IDLE;
                        push      = 1'b1;
`endif
                    end
                end
            end
`ifdef SER2PAR_PARITY_EN
            PAR: begin
                if (bus.sin_vld) begin
                    state_nxt = IDLE;
                    push      = 1'b1;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Bit counter and shift register; both hold while sin_vld is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            sreg <= '0;
        end else if (cnt_clr) begin
            cnt  <= '0;
            sreg <= '0;
        end else if (shift_en) begin
            sreg <= word_cur;
            cnt  <= (cnt == LAST_BIT) ? '0 : cnt + 1'b1;
        end
    end

    assign busy    = (state != IDLE);
    assign full    = (count == FULL_LVL);
    assign pop     = bus.out_vld && bus.out_rdy;
    // A push into a full FIFO is still taken when the head leaves that cycle.
    assign push_ok = push && (!full || pop);

    // FIFO storage; contents are only visible through out_vld-gated reads.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= push_ent;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    ovf <= 1'b0;
        else if (push && full && !pop) ovf <= 1'b1;
        else if (ovf_clr)            ovf <= 1'b0;
    end

    assign level        = count;
    assign bus.out_vld  = (count != '0);
    assign bus.out_data = bus.out_vld ? mem[rptr][WIDTH-1:0] : '0;
`ifdef SER2PAR_PARITY_EN
    assign bus.out_perr = bus.out_vld ? mem[rptr][WIDTH] : 1'b0;
`else
    assign bus.out_perr = 1'b0;
`endif

endmodule

// File: tb/tb_ser2par_deser.sv
// Bench for ser2par_deser: table of frames plus hand-written corner cases,
// with a queue of expected words checked whenever the FIFO head is taken.
module tb_ser2par_deser;

`ifdef SER2PAR_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] d;
        logic       perr;
    } exp_t;

    typedef struct {
        logic [7:0] word;
        int         stall_at;
        int         stall_len;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       ovf;
    logic       ovf_clr;
    logic       busy;
    logic [2:0] level;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    logic [7:0] last_pop = 8'h00;

    ser2par_deser_if #(.WIDTH(8)) s2cif ();

    ser2par_deser #(.WIDTH(8), .DEPTH(4), .START_VAL(1'b1)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (s2cif.slave),
        .ovf     (ovf),
        .ovf_clr (ovf_clr),
        .busy    (busy),
        .level   (level)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_perr(input logic [7:0] w, input logic p);
        return PAR_EN ? ((^w) ^ p) : 1'b0;
    endfunction

    // Scoreboard: every accepted head word is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && s2cif.out_vld === 1'b1 && s2cif.out_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL pop_unexpected: got %0h expected none", s2cif.out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pop_data", {24'd0, s2cif.out_data}, {24'd0, e.d});
                check("pop_perr", {31'd0, s2cif.out_perr}, {31'd0, e.perr});
                last_pop = s2cif.out_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        s2cif.sin     = b;
        s2cif.sin_vld = 1'b1;
        tick();
    endtask

    // Start bit, 8 data bits LSB first, optional parity; optional stall
    // before data bit stall_at; rdy_last raises out_rdy for the final bit only.
    task automatic send_frame(input logic [7:0] w, input logic p,
                              input int stall_at, input int stall_len,
                              input bit rdy_last);
        drive_bit(1'b1);
        for (int i = 0; i < 8; i++) begin
            if (i == stall_at) begin
                logic [2:0] lvl;
                lvl = level;
                for (int s = 0; s < stall_len; s++) begin
                    s2cif.sin     = 1'bx;
                    s2cif.sin_vld = 1'b0;
                    tick();
                    check("stall_busy", {31'd0, busy}, 32'd1);
                    check("stall_level", {29'd0, level}, {29'd0, lvl});
                end
            end
            if (i == 7 && !PAR_EN && rdy_last) s2cif.out_rdy = 1'b1;
            drive_bit(w[i]);
        end
        if (PAR_EN) begin
            if (rdy_last) s2cif.out_rdy = 1'b1;
            drive_bit(p);
        end
        s2cif.sin     = 1'b0;
        s2cif.sin_vld = 1'b0;
        if (rdy_last) s2cif.out_rdy = 1'b0;
    endtask

    task automatic drain();
        int k;
        s2cif.out_rdy = 1'b1;
        k = 0;
        while ((exp_q.size() != 0 || s2cif.out_vld) && k < 30) begin
            tick();
            k++;
        end
        check("drain_done", {31'd0, (exp_q.size() == 0 && !s2cif.out_vld)}, 32'd1);
        s2cif.out_rdy = 1'b0;
    endtask

    initial begin
        vec_t vecs[6];
        exp_t e;
        int   mdl_level;
        bit   exp_ovf;

        vecs[0] = '{word: 8'hA5, stall_at: -1, stall_len: 0};
        vecs[1] = '{word: 8'hA5, stall_at:  3, stall_len: 3};
        vecs[2] = '{word: 8'h3C, stall_at: -1, stall_len: 0};
        vecs[3] = '{word: 8'h00, stall_at:  0, stall_len: 2};
        vecs[4] = '{word: 8'hFF, stall_at:  7, stall_len: 1};
        vecs[5] = '{word: 8'h81, stall_at: -1, stall_len: 0};

        rst           = 1'b0;
        s2cif.sin     = 1'b0;
        s2cif.sin_vld = 1'b0;
        s2cif.out_rdy = 1'b0;
        ovf_clr       = 1'b0;
        #20;
        check("rst_out_vld", {31'd0, s2cif.out_vld}, 32'd0);
        check("rst_out_data", {24'd0, s2cif.out_data}, 32'd0);
        check("rst_out_perr", {31'd0, s2cif.out_perr}, 32'd0);
        check("rst_level", {29'd0, level}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        #5 rst = 1'b1;
        tick();

        // First frame with out_rdy low: word visible at the last-bit edge.
        e = '{d: 8'hA5, perr: exp_perr(8'hA5, 1'b0)};
        exp_q.push_back(e);
        send_frame(8'hA5, 1'b0, -1, 0, 1'b0);
        check("first_vld", {31'd0, s2cif.out_vld}, 32'd1);
        check("first_data", {24'd0, s2cif.out_data}, 32'hA5);
        check("first_level", {29'd0, level}, 32'd1);
        check("first_busy", {31'd0, busy}, 32'd0);
        drain();

        // Table of frames, consumer always ready, non-start noise between.
        s2cif.out_rdy = 1'b1;
        for (int v = 0; v < 6; v++) begin
            e = '{d: vecs[v].word, perr: exp_perr(vecs[v].word, 1'b0)};
            exp_q.push_back(e);
            send_frame(vecs[v].word, 1'b0, vecs[v].stall_at, vecs[v].stall_len, 1'b0);
            s2cif.out_rdy = 1'b1;
            check("vec_vld", {31'd0, s2cif.out_vld}, 32'd1);
            check("vec_data", {24'd0, s2cif.out_data}, {24'd0, vecs[v].word});
            check("vec_level", {29'd0, level}, 32'd1);
            check("vec_busy", {31'd0, busy}, 32'd0);
            drive_bit(1'b0);
            check("noise_idle", {31'd0, busy}, 32'd0);
            s2cif.sin_vld = 1'b0;
            tick();
        end
        drain();

        // Back-to-back fill past capacity with the consumer stalled.
        mdl_level = 0;
        exp_ovf   = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (mdl_level < 4) begin
                e = '{d: 8'(k), perr: exp_perr(8'(k), 1'b0)};
                exp_q.push_back(e);
                mdl_level++;
            end else begin
                exp_ovf = 1'b1;
            end
            send_frame(8'(k), 1'b0, -1, 0, 1'b0);
            check("fill_level", {29'd0, level}, mdl_level);
            check("fill_ovf", {31'd0, ovf}, {31'd0, exp_ovf});
        end
        drain();
        check("drain_last", {24'd0, last_pop}, 32'h04);
        check("ovf_sticky", {31'd0, ovf}, 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", {31'd0, ovf}, 32'd0);

        // Full FIFO with a pop on the same edge the new word arrives.
        for (int k = 1; k <= 4; k++) begin
            e = '{d: 8'(k * 17), perr: exp_perr(8'(k * 17), 1'b0)};
            exp_q.push_back(e);
            send_frame(8'(k * 17), 1'b0, -1, 0, 1'b0);
        end
        check("full_level", {29'd0, level}, 32'd4);
        e = '{d: 8'h3C, perr: exp_perr(8'h3C, 1'b0)};
        exp_q.push_back(e);
        send_frame(8'h3C, 1'b0, -1, 0, 1'b1);
        check("fullpop_level", {29'd0, level}, 32'd4);
        check("fullpop_ovf", {31'd0, ovf}, 32'd0);
        drain();
        check("fullpop_last", {24'd0, last_pop}, 32'h3C);

        // Reset in the middle of a frame with two words buffered.
        for (int k = 0; k < 2; k++) begin
            e = '{d: 8'h5A ^ 8'(k), perr: exp_perr(8'h5A ^ 8'(k), 1'b0)};
            exp_q.push_back(e);
            send_frame(8'h5A ^ 8'(k), 1'b0, -1, 0, 1'b0);
        end
        check("pre_rst_level", {29'd0, level}, 32'd2);
        drive_bit(1'b1);
        for (int i = 0; i < 4; i++) drive_bit(1'(i));
        s2cif.sin_vld = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("mid_rst_vld", {31'd0, s2cif.out_vld}, 32'd0);
        check("mid_rst_level", {29'd0, level}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        tick();
        e = '{d: 8'hFF, perr: exp_perr(8'hFF, 1'b0)};
        exp_q.push_back(e);
        send_frame(8'hFF, 1'b0, -1, 0, 1'b0);
        check("post_rst_data", {24'd0, s2cif.out_data}, 32'hFF);
        check("post_rst_level", {29'd0, level}, 32'd1);
        drain();

        // Parity flag: good parity then bad parity on the same word.
        e = '{d: 8'hA5, perr: exp_perr(8'hA5, 1'b0)};
        exp_q.push_back(e);
        send_frame(8'hA5, 1'b0, -1, 0, 1'b0);
        check("par0_perr", {31'd0, s2cif.out_perr}, {31'd0, exp_perr(8'hA5, 1'b0)});
        e = '{d: 8'hA5, perr: exp_perr(8'hA5, 1'b1)};
        exp_q.push_back(e);
        send_frame(8'hA5, 1'b1, -1, 0, 1'b0);
        check("par_level", {29'd0, level}, 32'd2);
        drain();
        check("end_queue", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
